// File: rtl/pll_ctrl_pkg.sv
// Shared types and defaults for the system PLL reset/lock sequencer.
package pll_ctrl_pkg;

    typedef enum logic [2:0] {
        RESET_PLL,
        WAIT_LOCK,
        STABLE,
        RELEASE,
        RUN,
        FAIL
    } pll_seq_state_t;

    localparam int unsigned NUM_DOMAINS = 3;

    localparam int unsigned DEF_RST_CYCLES    = 16;
    localparam int unsigned DEF_LOCK_TIMEOUT  = 50000;
    localparam int unsigned DEF_STABLE_CYCLES = 1024;
    localparam int unsigned DEF_STAGGER       = 8;
    localparam int unsigned DEF_MAX_RETRY     = 3;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// Two-flop synchroniser bringing the asynchronous PLL lock into the refclk domain.
module pll_lock_sync (
    input  logic clk,
    input  logic rst,
    input  logic locked,
    output logic lock_s
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta   <= 1'b0;
            lock_s <= 1'b0;
        end else begin
            meta   <= locked;
            lock_s <= meta;
        end
    end

endmodule

// File: rtl/pll_lock_sequencer.sv
// PLL reset pulse, lock wait with bounded retries, staggered domain reset
// release, and run-time supervision of lock loss / relock requests.
module pll_lock_sequencer
    import pll_ctrl_pkg::*;
#(
    parameter int unsigned RST_CYCLES    = DEF_RST_CYCLES,
    parameter int unsigned LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
    parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int unsigned STAGGER       = DEF_STAGGER,
    parameter int unsigned MAX_RETRY     = DEF_MAX_RETRY
) (
    input  logic                   refclk,
    input  logic                   rst,
    input  logic                   locked,
    input  logic                   relock_req,
    output logic                   pll_rst,
    output logic [NUM_DOMAINS-1:0] domain_rst,
    output logic                   ready,
    output logic                   fail,
    output logic [1:0]             retry_cnt,
    output logic [7:0]             loss_cnt
);

    localparam int unsigned CNT_SPAN = max_u(max_u(LOCK_TIMEOUT, STABLE_CYCLES),
                                             max_u(RST_CYCLES, STAGGER));
    localparam int unsigned CW = (CNT_SPAN > 1) ? $clog2(CNT_SPAN) : 1;
    localparam int unsigned IW = $clog2(NUM_DOMAINS);

    localparam logic [CW-1:0] RST_LAST     = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] STABLE_LAST  = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] STAGGER_LAST = CW'(STAGGER - 1);
    localparam logic [IW-1:0] IDX_LAST     = IW'(NUM_DOMAINS - 1);
    localparam logic [1:0]    RETRY_LIMIT  = 2'(MAX_RETRY);

    logic           lock_s;
    pll_seq_state_t state, state_n;
    logic [CW-1:0]  cnt, cnt_n;
    logic [IW-1:0]  idx, idx_n;
    logic [1:0]     retry_n;
    logic [7:0]     loss_n;
    logic           retry_path;
    logic           restart;

    pll_lock_sync u_sync (
        .clk    (refclk),
        .rst    (rst),
        .locked (locked),
        .lock_s (lock_s)
    );

    always_ff @(posedge refclk) begin
        if (rst) begin
            state     <= RESET_PLL;
            cnt       <= '0;
            idx       <= '0;
            retry_cnt <= '0;
            loss_cnt  <= '0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            idx       <= idx_n;
            retry_cnt <= retry_n;
            loss_cnt  <= loss_n;
        end
    end

    always_comb begin
        state_n    = state;
        idx_n      = idx;
        retry_n    = retry_cnt;
        loss_n     = loss_cnt;
        retry_path = 1'b0;
        restart    = 1'b0;
        case (state)
            RESET_PLL: if (cnt == RST_LAST) state_n = WAIT_LOCK;
            WAIT_LOCK: begin
                if (lock_s)                     state_n = STABLE;
                else if (cnt == TIMEOUT_LAST)   retry_path = 1'b1;
            end
            STABLE: begin
                if (!lock_s) begin
                    retry_path = 1'b1;
                end else if (cnt == STABLE_LAST) begin
                    state_n = RELEASE;
                    idx_n   = '0;
                end
            end
            RELEASE: begin
                if (!lock_s) begin
                    retry_path = 1'b1;
                end else if (idx == IDX_LAST) begin
                    state_n = RUN;
                end else if (cnt == STAGGER_LAST) begin
                    // the stagger timer is re-armed per domain without leaving the state
                    idx_n   = idx + 1'b1;
                    restart = 1'b1;
                end
            end
            RUN: begin
                if (!lock_s) begin
                    if (loss_cnt != '1) loss_n = loss_cnt + 8'd1;
                    retry_n = '0;
                    state_n = RESET_PLL;
                end else if (relock_req) begin
                    retry_n = '0;
                    state_n = RESET_PLL;
                end
            end
            FAIL: begin
                if (relock_req) begin
                    retry_n = '0;
                    state_n = RESET_PLL;
                end
            end
            default: state_n = RESET_PLL;
        endcase

        if (retry_path) begin
            if (retry_cnt == RETRY_LIMIT) begin
                state_n = FAIL;
            end else begin
                retry_n = retry_cnt + 2'd1;
                state_n = RESET_PLL;
            end
        end

        if (state_n != state || restart)   cnt_n = '0;
        else if (state == RUN || state == FAIL) cnt_n = cnt;
        else                                cnt_n = cnt + 1'b1;
    end

    always_comb begin
        pll_rst    = (state == RESET_PLL) || (state == FAIL);
        ready      = (state == RUN);
        fail       = (state == FAIL);
        domain_rst = '1;
        if (state == RUN) begin
            domain_rst = '0;
        end else if (state == RELEASE) begin
            for (int unsigned i = 0; i < NUM_DOMAINS; i++) begin
                if (IW'(i) <= idx) domain_rst[i] = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Scoreboard bench: a time-elapsed reference model predicts every cycle's outputs.
module tb_pll_lock_sequencer;

    localparam int unsigned RST_C = 4;
    localparam int unsigned TO    = 32;
    localparam int unsigned STAB  = 8;
    localparam int unsigned STAG  = 2;
    localparam int unsigned MAXR  = 2;
    localparam int unsigned ND    = 3;

    logic       refclk = 1'b0;
    logic       rst = 1'b1;
    logic       locked = 1'b0;
    logic       relock_req = 1'b0;
    logic       pll_rst;
    logic [2:0] domain_rst;
    logic       ready;
    logic       fail;
    logic [1:0] retry_cnt;
    logic [7:0] loss_cnt;

    pll_lock_sequencer #(
        .RST_CYCLES   (RST_C),
        .LOCK_TIMEOUT (TO),
        .STABLE_CYCLES(STAB),
        .STAGGER      (STAG),
        .MAX_RETRY    (MAXR)
    ) dut (
        .refclk    (refclk),
        .rst       (rst),
        .locked    (locked),
        .relock_req(relock_req),
        .pll_rst   (pll_rst),
        .domain_rst(domain_rst),
        .ready     (ready),
        .fail      (fail),
        .retry_cnt (retry_cnt),
        .loss_cnt  (loss_cnt)
    );

    always #5 refclk = ~refclk;

    typedef struct packed {
        logic       pll_rst;
        logic [2:0] domain_rst;
        logic       ready;
        logic       fail;
        logic [1:0] retry_cnt;
        logic [7:0] loss_cnt;
    } obs_t;

    obs_t  sb[$];
    int    n_checks = 0;
    int    n_fail = 0;
    int    cyc = 0;
    bit    started = 1'b0;

    // Reference model: phase name plus cycles elapsed in that phase.
    string phase = "RESET";
    int    t = 0;
    int    retries = 0;
    int    losses = 0;
    bit    s1 = 1'b0;
    bit    s2 = 1'b0;

    function automatic obs_t predict();
        obs_t o;
        int   n;
        o.pll_rst    = (phase == "RESET") || (phase == "FAIL");
        o.ready      = (phase == "RUN");
        o.fail       = (phase == "FAIL");
        o.domain_rst = 3'b111;
        if (phase == "RUN") o.domain_rst = 3'b000;
        if (phase == "RELEASE") begin
            n = t / STAG + 1;
            if (n > ND) n = ND;
            for (int i = 0; i < n; i++) o.domain_rst[i] = 1'b0;
        end
        o.retry_cnt = 2'(retries);
        o.loss_cnt  = 8'(losses);
        return o;
    endfunction

    always @(posedge refclk) begin
        bit    ls;
        string np;
        ls = s2;
        s2 = s1;
        s1 = locked;
        cyc++;
        if (rst) begin
            phase = "RESET"; t = 0; retries = 0; losses = 0; s1 = 1'b0; s2 = 1'b0;
        end else begin
            np = phase;
            if (phase == "RESET") begin
                if (t == RST_C - 1) np = "WAIT";
            end else if (phase == "WAIT") begin
                if (ls) np = "STABLE";
                else if (t == TO - 1) np = "RETRY";
            end else if (phase == "STABLE") begin
                if (!ls) np = "RETRY";
                else if (t == STAB - 1) np = "RELEASE";
            end else if (phase == "RELEASE") begin
                if (!ls) np = "RETRY";
                else if (t == (ND - 1) * STAG) np = "RUN";
            end else if (phase == "RUN") begin
                if (!ls) begin
                    if (losses < 255) losses++;
                    retries = 0; np = "RESET";
                end else if (relock_req) begin
                    retries = 0; np = "RESET";
                end
            end else if (phase == "FAIL") begin
                if (relock_req) begin
                    retries = 0; np = "RESET";
                end
            end
            if (np == "RETRY") begin
                if (retries == MAXR) np = "FAIL";
                else begin retries++; np = "RESET"; end
            end
            if (np == phase) t++;
            else t = 0;
            phase = np;
        end
        sb.push_back(predict());
        started = 1'b1;
    end

    always @(negedge refclk) begin
        obs_t got;
        obs_t exp;
        if (started) begin
            got = {pll_rst, domain_rst, ready, fail, retry_cnt, loss_cnt};
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL scoreboard_empty cycle %0d: no expected entry", cyc);
            end else begin
                exp = sb.pop_front();
                if (got !== exp) begin
                    n_fail++;
                    $display("FAIL outputs cycle %0d (%s t=%0d): got pll_rst=%b domain_rst=%b ready=%b fail=%b retry_cnt=%0d loss_cnt=%0d, expected pll_rst=%b domain_rst=%b ready=%b fail=%b retry_cnt=%0d loss_cnt=%0d",
                             cyc, phase, t, got.pll_rst, got.domain_rst, got.ready, got.fail,
                             got.retry_cnt, got.loss_cnt, exp.pll_rst, exp.domain_rst, exp.ready,
                             exp.fail, exp.retry_cnt, exp.loss_cnt);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge refclk);
    endtask

    task automatic wait_phase(input string p, input int budget);
        int k;
        k = 0;
        while (phase != p && k < budget) begin
            @(negedge refclk);
            k++;
        end
        if (phase != p) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_%s: phase %s after %0d cycles, required %s", p, phase, budget, p);
        end
    endtask

    task automatic pulse_relock();
        relock_req = 1'b1;
        step(1);
        relock_req = 1'b0;
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; locked = 1'b0; relock_req = 1'b0;
        step(3);
        rst = 1'b0;

        // clean bring-up
        step(10);
        locked = 1'b1;
        wait_phase("RUN", 100);
        step(5);

        // lock loss in RUN, relock_req while waiting for lock is ignored
        locked = 1'b0;
        wait_phase("WAIT", 20);
        step(3);
        pulse_relock();
        step(2);
        pulse_relock();
        step($urandom_range(0, 5));
        locked = 1'b1;
        wait_phase("RUN", 100);

        // plain relock request in RUN
        step(3);
        pulse_relock();
        wait_phase("RUN", 100);

        // glitch during STABLE
        locked = 1'b0; step(1); locked = 1'b1;
        wait_phase("STABLE", 50);
        step(2);
        locked = 1'b0; step(1); locked = 1'b1;
        wait_phase("RESET", 10);
        wait_phase("RUN", 100);

        // relock_req coinciding with synchronised lock loss
        step(4);
        locked = 1'b0;
        step(2);
        relock_req = 1'b1;
        step(1);
        relock_req = 1'b0;
        locked = 1'b1;
        wait_phase("RUN", 100);

        // repeated losses to saturate loss_cnt
        for (int i = 0; i < 260; i++) begin
            step($urandom_range(0, 4));
            locked = 1'b0;
            step($urandom_range(1, 3));
            locked = 1'b1;
            wait_phase("RESET", 10);
            if ($urandom_range(0, 1) == 1) pulse_relock();
            wait_phase("RUN", 100);
        end

        // exhausted retries, then recovery
        locked = 1'b0;
        wait_phase("FAIL", 300);
        step(5);
        locked = 1'b1;
        step(4);
        pulse_relock();
        wait_phase("RUN", 100);

        // reset in the middle of RELEASE with domain_rst=100
        locked = 1'b0; step(1); locked = 1'b1;
        wait_phase("RESET", 10);
        wait_phase("RELEASE", 100);
        for (int k = 0; k < 10 && phase == "RELEASE" && t < STAG; k++) step(1);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        wait_phase("RUN", 100);

        // random lock / relock activity
        for (int seg = 0; seg < 40; seg++) begin
            int dur;
            locked = ($urandom_range(0, 3) != 0);
            dur = $urandom_range(1, 40);
            for (int k = 0; k < dur; k++) begin
                relock_req = ($urandom_range(0, 7) == 0);
                step(1);
            end
            relock_req = 1'b0;
        end

        step(3);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
